// File: rtl/morse_encoder_tx.sv
// Morse code transmitter: takes ASCII characters over valid/ready and keys them out with unit timing.
// When a character finishes, it echoes that character in the decoder's index/data format.
`timescale 1ns/1ps
module morse_encoder_tx #(
   parameter int UNIT_CYCLES = 10000000
) (
   input  logic       clk_100Mhz,
   input  logic       reset,
   input  logic       char_valid,
   input  logic [7:0] char_ascii,
   output logic       char_ready,
   output logic       key_out,
   output logic       busy,
   output logic       err,
   output logic       echo_valid,
   output logic [2:0] echo_index,
   output logic [5:0] echo_data
);

   localparam int CW = $clog2(UNIT_CYCLES);
   localparam logic [CW-1:0] UNIT_LAST = CW'(UNIT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, MARK, GAP, CHAR_GAP, WORD_GAP} state_t;

   // Returns {len-1, pattern}. The first element is held at pattern[len-1].
   function automatic logic [5:0] lookup(input logic [4:0] idx);
      case (idx)
         5'd0:  lookup = {2'd1, 4'b0001}; // A
         5'd1:  lookup = {2'd3, 4'b1000}; // B
         5'd2:  lookup = {2'd3, 4'b1010}; // C
         5'd3:  lookup = {2'd2, 4'b0100}; // D
         5'd4:  lookup = {2'd0, 4'b0000}; // E
         5'd5:  lookup = {2'd3, 4'b0010}; // F
         5'd6:  lookup = {2'd2, 4'b0110}; // G
         5'd7:  lookup = {2'd3, 4'b0000}; // H
         5'd8:  lookup = {2'd1, 4'b0000}; // I
         5'd9:  lookup = {2'd3, 4'b0111}; // J
         5'd10: lookup = {2'd2, 4'b0101}; // K
         5'd11: lookup = {2'd3, 4'b0100}; // L
         5'd12: lookup = {2'd1, 4'b0011}; // M
         5'd13: lookup = {2'd1, 4'b0010}; // N
         5'd14: lookup = {2'd2, 4'b0111}; // O
         5'd15: lookup = {2'd3, 4'b0110}; // P
         5'd16: lookup = {2'd3, 4'b1101}; // Q
         5'd17: lookup = {2'd2, 4'b0010}; // R
         5'd18: lookup = {2'd2, 4'b0000}; // S
         5'd19: lookup = {2'd0, 4'b0001}; // T
         5'd20: lookup = {2'd2, 4'b0001}; // U
         5'd21: lookup = {2'd3, 4'b0001}; // V
         5'd22: lookup = {2'd2, 4'b0011}; // W
         5'd23: lookup = {2'd3, 4'b1001}; // X
         5'd24: lookup = {2'd3, 4'b1011}; // Y
         5'd25: lookup = {2'd3, 4'b1100}; // Z
         default: lookup = 6'd0;
      endcase
   endfunction

   state_t        state;
   logic [CW-1:0] unit_cnt;
   logic [2:0]    units_left;
   logic [3:0]    pat;
   logic [1:0]    len_m1;
   logic [1:0]    elem;

   // Clearing bit 5 folds lower case to upper case. Only the two letter ranges land in 0x41-0x5A.
   logic [7:0] up;
   logic       is_letter, is_space, unit_done, step_done;
   logic [5:0] code;
   logic [1:0] next_elem;

   assign up         = char_ascii & 8'hDF;
   assign is_letter  = (up >= 8'h41) && (up <= 8'h5A);
   assign is_space   = (char_ascii == 8'h20);
   assign code       = lookup(up[4:0] - 5'd1);
   assign unit_done  = (unit_cnt == UNIT_LAST);
   assign step_done  = unit_done && (units_left == 3'd1);
   assign next_elem  = elem - 2'd1;
   assign char_ready = (state == IDLE);
   assign busy       = ~char_ready;

   always_ff @(posedge clk_100Mhz) begin
      if (reset) begin
         state      <= IDLE;
         key_out    <= 1'b0;
         err        <= 1'b0;
         echo_valid <= 1'b0;
         echo_index <= 3'd0;
         echo_data  <= 6'd0;
         unit_cnt   <= '0;
         units_left <= 3'd0;
         pat        <= 4'd0;
         len_m1     <= 2'd0;
         elem       <= 2'd0;
      end else begin
         err        <= 1'b0;
         echo_valid <= 1'b0;
         // Shared unit timebase. A state transition below overrides units_left.
         if (state != IDLE) begin
            if (unit_done) begin
               unit_cnt <= '0;
               if (units_left != 3'd1) units_left <= units_left - 3'd1;
            end else begin
               unit_cnt <= unit_cnt + 1'b1;
            end
         end
         case (state)
            IDLE: begin
               if (char_valid) begin
                  if (is_letter) begin
                     state      <= MARK;
                     key_out    <= 1'b1;
                     len_m1     <= code[5:4];
                     pat        <= code[3:0];
                     elem       <= code[5:4];
                     units_left <= code[code[5:4]] ? 3'd3 : 3'd1;
                  end else if (is_space) begin
                     state      <= WORD_GAP;
                     units_left <= 3'd4;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            MARK: if (step_done) begin
               key_out <= 1'b0;
               if (elem != 2'd0) begin
                  state      <= GAP;
                  units_left <= 3'd1;
               end else begin
                  state      <= CHAR_GAP;
                  units_left <= 3'd3;
               end
            end
            GAP: if (step_done) begin
               state      <= MARK;
               key_out    <= 1'b1;
               elem       <= next_elem;
               units_left <= pat[next_elem] ? 3'd3 : 3'd1;
            end
            CHAR_GAP: if (step_done) begin
               state      <= IDLE;
               echo_valid <= 1'b1;
               echo_index <= {1'b0, len_m1};
               echo_data  <= {2'b00, pat};
            end
            WORD_GAP: if (step_done) begin
               state      <= IDLE;
               echo_valid <= 1'b1;
               echo_index <= 3'b101;
               echo_data  <= 6'd0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
